logic_gate_unit: RTL and testbench
==================================

// Module: logic_gate_unit
// PURPOSE
//  Parametrised, pipelined bitwise logic unit: AND/NAND/OR/NOR/XOR/XNOR/NOT/PASS on two WIDTH-bit operands.
//  Successor to the single fixed-function two-input gate blocks: the op is selectable, the datapath is
//  pipelined with valid/ready handshakes, and a truth-table sweep mode self-generates minterms m=0..3.
//  Sits between an operand source and a result sink, or stands alone as a gate characteriser.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      operand beat present
//  in_ready    out  1      unit accepts operand beat
//  in_a        in   WIDTH  operand a
//  in_b        in   WIDTH  operand b (ignored by NOT/PASS)
//  in_op       in   3      op code, see BEHAVIOUR
//  out_valid   out  1      result beat present
//  out_ready   in   1      sink accepts result
//  out_y       out  WIDTH  result
//  sweep_start in   1      request truth-table sweep
//  sweep_op    in   3      op code used by the sweep
//  sweep_busy  out  1      sweep in progress
//  tt_out      out  4      truth table, bit m = f(a=m[1], b=m[0])
//  tt_valid    out  1      one-cycle pulse: tt_out updated
// BEHAVIOUR
//  Op codes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 PASS a; applied bitwise.
//  Reset (async, rst_n=0): s1/s2 valid=0, out_y=0, out_valid=0, tt_out=0, tt_valid=0, FSM=IDLE,
//   sweep counter=0; in_ready=1 from first edge after release. Reset mid-sweep aborts it, no tt_valid.
//  Pipeline: stage1 registers {a,b,op}; stage2 registers result y. adv = !s2_valid | out_ready.
//   s2 loads from s1 when adv; s1 loads when in_valid&in_ready; in_ready = !s1_valid | adv (no comb
//   path from in_valid to in_ready). Latency: beat accepted at edge N -> out_valid at edge N+2.
//   Full throughput (1 beat/cycle) when out_ready=1. out_y/out_valid stable while out_valid&!out_ready.
//   Order preserved; max 2 beats in flight; none dropped or duplicated.
//  FSM: IDLE -> SWEEP -> IDLE.
//   IDLE: sweep_start=1 AND s1,s2 empty at edge E -> SWEEP, sweep_busy=1. Otherwise sweep_start is
//    ignored (not queued). sweep_op sampled at E only.
//   SWEEP: in_ready=0; item m (a={WIDTH{m[1]}}, b={WIDTH{m[0]}}) injected into s1 at edge E+1+m, m=0..3.
//    Sweep items are tagged, never raise out_valid, never stall (out_ready ignored).
//    Item m leaves s2 at edge E+3+m writing tt_out[m] = y[0]. At E+6: tt_valid=1 (one cycle),
//    FSM->IDLE, sweep_busy=0. tt_out holds until next sweep completes or reset.
//  Simultaneous in_valid and sweep_start in IDLE with empty pipe: sweep wins, operand not accepted.
//  Op codes 6/7: b ignored entirely.
// STRUCTURE
//  logic_gate_pkg: op-code localparams (OP_AND..OP_PASS), FSM state encoding.
//  Sub-module logic_gate_core: combinational (a,b,op)->y, WIDTH-parametrised; instanced once.
//  Top holds pipeline registers, handshake, sweep FSM/counter, tt register.
// TESTING
//  1 Reset: hold rst_n=0 mid-stream -> all outputs 0 immediately; after release in_ready=1, tt_out=0.
//  2 Stream NAND a=8'hF0 b=8'hCC, out_ready=1 -> out_y=8'h3F, out_valid at accept edge +2; then
//    NOR a=8'h0F b=8'h33 back-to-back -> 8'hC0 next cycle.
//  3 Backpressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0; release -> all 3 emerge in order.
//  4 Sweep sweep_op=NAND -> tt_out=4'b0111, tt_valid at E+6 for one cycle; NOR -> 4'b0001;
//    XOR -> 4'b0110; AND -> 4'b1000; out_valid stays 0 throughout.
//  5 sweep_start while a beat is in flight -> ignored, sweep_busy stays 0, beat delivered intact.
//  6 Assert rst_n=0 at E+4 of sweep -> no tt_valid, tt_out=0, FSM IDLE after release.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: op codes and sweep FSM states shared by the logic gate unit files
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_PASS = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } state_t;

endpackage

// File: rtl/logic_gate_core.sv
// logic_gate_core: combinational bitwise gate y = f(a, b, op)
//  a, b : WIDTH-bit operands (b unused by NOT/PASS)
//  op   : 3-bit op code
//  y    : WIDTH-bit result
module logic_gate_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);
    import logic_gate_pkg::*;

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_NAND: y = ~(a & b);
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_PASS: y = a;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: two-stage pipelined bitwise logic unit with truth-table sweep mode
//  clk, rst_n                   : clock, async active-low reset
//  in_valid/in_ready/a/b/op     : operand beat handshake
//  out_valid/out_ready/out_y    : result beat handshake
//  sweep_start/sweep_op         : request a 4-minterm sweep of sweep_op
//  sweep_busy, tt_out, tt_valid : sweep status, truth table, completion pulse
module logic_gate_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    input  logic             sweep_start,
    input  logic [2:0]       sweep_op,
    output logic             sweep_busy,
    output logic [3:0]       tt_out,
    output logic             tt_valid
);
    import logic_gate_pkg::*;

    state_t           state, state_nx;
    logic [2:0]       cnt, sw_op;
    logic             rdy_en;
    logic             s1_valid, s1_tag, s2_valid, s2_tag;
    logic [1:0]       s1_idx, s2_idx;
    logic [WIDTH-1:0] s1_a, s1_b, s2_y, core_y;
    logic [2:0]       s1_op;
    logic [3:0]       tt_acc, tt_nx;
    logic             adv, start_ok, inject, accept, sweep_done;

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .a  (s1_a),
        .b  (s1_b),
        .op (s1_op),
        .y  (core_y)
    );

    // tagged sweep items never wait on the sink
    assign adv        = !s2_valid || s2_tag || out_ready;
    assign start_ok   = rdy_en && state == ST_IDLE && sweep_start && !s1_valid && !s2_valid;
    // rdy_en holds in_ready low until the first edge after reset release
    assign in_ready   = rdy_en && state == ST_IDLE && !start_ok && (!s1_valid || adv);
    assign accept     = in_valid && in_ready;
    // cnt counts edges since sweep entry: inject at 0..3, last item leaves s2 at 5
    assign inject     = state == ST_SWEEP && !cnt[2];
    assign sweep_done = state == ST_SWEEP && cnt == 3'd5;
    assign sweep_busy = state == ST_SWEEP;
    assign out_valid  = s2_valid && !s2_tag;
    assign out_y      = s2_y;

    always_comb begin
        state_nx = start_ok ? ST_SWEEP : sweep_done ? ST_IDLE : state;
        tt_nx = tt_acc;
        if (s2_valid && s2_tag) tt_nx[s2_idx] = s2_y[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sw_op    <= '0;
            rdy_en   <= 1'b0;
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_idx   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s2_valid <= 1'b0;
            s2_tag   <= 1'b0;
            s2_idx   <= '0;
            s2_y     <= '0;
            tt_acc   <= '0;
            tt_out   <= '0;
            tt_valid <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            state    <= state_nx;
            cnt      <= start_ok ? 3'd0 : sweep_busy ? cnt + 3'd1 : cnt;
            if (start_ok) sw_op <= sweep_op;
            if (inject) begin
                s1_valid <= 1'b1;
                s1_tag   <= 1'b1;
                s1_idx   <= cnt[1:0];
                s1_a     <= {WIDTH{cnt[1]}};
                s1_b     <= {WIDTH{cnt[0]}};
                s1_op    <= sw_op;
            end else if (accept) begin
                s1_valid <= 1'b1;
                s1_tag   <= 1'b0;
                s1_idx   <= '0;
                s1_a     <= in_a;
                s1_b     <= in_b;
                s1_op    <= in_op;
            end else if (adv) begin
                s1_valid <= 1'b0;
            end
            if (adv) begin
                s2_valid <= s1_valid;
                s2_tag   <= s1_tag;
                if (s1_valid) s2_idx <= s1_idx;
                if (s1_valid) s2_y <= core_y;
            end
            tt_acc   <= tt_nx;
            tt_valid <= sweep_done;
            if (sweep_done) tt_out <= tt_nx;
        end
    end

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb_logic_gate_unit: directed-vector self-checking bench for logic_gate_unit
module tb_logic_gate_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b1, sweep_start = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic [2:0] in_op = '0, sweep_op = '0;
    logic       in_ready, out_valid, sweep_busy, tt_valid;
    logic [7:0] out_y;
    logic [3:0] tt_out;
    int         n_cmp = 0, n_err = 0;

    logic_gate_unit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .sweep_start (sweep_start),
        .sweep_op    (sweep_op),
        .sweep_busy  (sweep_busy),
        .tt_out      (tt_out),
        .tt_valid    (tt_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
    endtask

    // sweep request at edge E, checks through E+7
    task automatic sweep(input logic [2:0] op, input logic [3:0] exp);
        logic seen;
        sweep_start = 1'b1;
        sweep_op = op;
        out_ready = 1'b0;
        tick;
        sweep_start = 1'b0;
        sweep_op = op ^ 3'd7;
        check("sweep_busy_on", sweep_busy, 1);
        check("sweep_in_ready", in_ready, 0);
        seen = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick;
            seen = seen | out_valid | tt_valid;
        end
        check("sweep_quiet", seen, 0);
        tick;
        check("tt_valid_pulse", tt_valid, 1);
        check("tt_out", tt_out, exp);
        check("sweep_busy_off", sweep_busy, 0);
        check("sweep_out_valid", out_valid, 0);
        tick;
        check("tt_valid_drop", tt_valid, 0);
        check("tt_out_hold", tt_out, exp);
        out_ready = 1'b1;
    endtask

    logic [2:0] v_op [5] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
    logic [7:0] v_y  [5] = '{8'h24, 8'hBD, 8'h99, 8'h5A, 8'hA5};

    initial begin
        logic seen;
        // reset and mid-stream reset
        repeat (2) tick;
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick;
        check("rel_in_ready", in_ready, 1);
        check("rel_tt_out", tt_out, 0);
        beat(3'd2, 8'h11, 8'h22);
        tick;
        in_valid = 1'b0;
        tick;
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_y", out_y, 0);
        check("rst_in_ready_mid", in_ready, 0);
        check("rst_tt_valid", tt_valid, 0);
        tick;
        rst_n = 1'b1;
        tick;
        check("rel2_in_ready", in_ready, 1);
        check("rel2_out_valid", out_valid, 0);

        // NAND then NOR back to back: captured at N, transferred at N+2
        beat(3'd1, 8'hF0, 8'hCC);
        tick;
        check("lat_n", out_valid, 0);
        beat(3'd3, 8'h0F, 8'h33);
        tick;
        in_valid = 1'b0;
        check("nand_valid", out_valid, 1);
        check("nand_y", out_y, 8'h3F);
        tick;
        check("nor_valid", out_valid, 1);
        check("nor_y", out_y, 8'hC0);
        tick;
        check("stream_drain", out_valid, 0);

        // remaining ops streamed at full rate
        for (int i = 0; i < 5; i++) begin
            beat(v_op[i], 8'hA5, 8'h3C);
            tick;
            if (i > 0) check("op_stream", out_y, v_y[i-1]);
        end
        in_valid = 1'b0;
        tick;
        check("op_stream_last", out_y, v_y[4]);
        tick;

        // backpressure
        out_ready = 1'b0;
        beat(3'd0, 8'hAA, 8'h0F);
        tick;
        check("bp_ready1", in_ready, 1);
        beat(3'd2, 8'hA0, 8'h05);
        tick;
        check("bp_full", in_ready, 0);
        check("bp_y0", out_y, 8'h0A);
        beat(3'd4, 8'hFF, 8'h0F);
        tick;
        check("bp_stall", in_ready, 0);
        check("bp_hold_y", out_y, 8'h0A);
        check("bp_hold_v", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_release", in_ready, 1);
        tick;
        in_valid = 1'b0;
        check("bp_y1", out_y, 8'hA5);
        tick;
        check("bp_y2", out_y, 8'hF0);
        tick;
        check("bp_empty", out_valid, 0);

        // truth-table sweeps
        sweep(3'd1, 4'b0111);
        sweep(3'd3, 4'b0001);
        sweep(3'd4, 4'b0110);
        sweep(3'd0, 4'b1000);

        // sweep request with a beat in flight is dropped
        beat(3'd5, 8'h3C, 8'h0F);
        tick;
        in_valid = 1'b0;
        sweep_start = 1'b1;
        sweep_op = 3'd1;
        tick;
        sweep_start = 1'b0;
        check("ign_busy", sweep_busy, 0);
        check("ign_y", out_y, 8'hCC);
        check("ign_valid", out_valid, 1);
        tick;
        check("ign_busy2", sweep_busy, 0);
        check("ign_drain", out_valid, 0);
        check("ign_tt", tt_out, 4'b1000);

        // reset at E+4 of a sweep
        sweep_start = 1'b1;
        sweep_op = 3'd4;
        tick;
        sweep_start = 1'b0;
        repeat (4) tick;
        rst_n = 1'b0;
        #1;
        check("abort_busy", sweep_busy, 0);
        check("abort_tt", tt_out, 0);
        check("abort_tt_valid", tt_valid, 0);
        tick;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick;
            seen = seen | tt_valid | sweep_busy;
        end
        check("abort_quiet", seen, 0);
        check("abort_tt_after", tt_out, 0);
        check("abort_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
